data_sram_responder: RTL and testbench
======================================

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: number of word-index bits, giving 2^ADDR_WIDTH 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from a request becoming queue head to its data_ok.
REQ-003 SHALL have parameter DEPTH, default 2, legal range 1..4: maximum number of accepted requests not yet responded to.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port data_req  input  1: initiator request valid.
REQ-007 SHALL have port data_wr  input  1: 1 = write, 0 = read.
REQ-008 SHALL have port data_size  input  2: 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
REQ-009 SHALL have port data_addr  input  32: byte address.
REQ-010 SHALL have port data_wdata  input  32: write data, lane-aligned to the address.
REQ-011 SHALL have port data_rdata  output  32: read data, valid only in a read's data_ok cycle.
REQ-012 SHALL have port data_addr_ok  output  1: request accepted this cycle when data_req is also 1.
REQ-013 SHALL have port data_data_ok  output  1: single-cycle response pulse, one per accepted request.

Function
REQ-014 SHALL treat a request as accepted in any cycle with data_req=1 and data_addr_ok=1, and SHALL push {wr, size, addr, wdata} into an in-order queue of DEPTH entries.
REQ-015 SHALL drive data_addr_ok = (queue count < DEPTH); it SHALL NOT depend on data_req, and a push into a full queue SHALL NOT occur even if a pop happens in the same cycle.
REQ-016 SHALL hold a head countdown counter, loaded with LATENCY-1 on the edge where an entry becomes head (push into an empty queue, or promotion on pop), and decremented each cycle while nonzero.
REQ-017 SHALL assert data_data_ok combinationally when the queue is nonempty and the counter is 0, and SHALL pop the head on that edge.
REQ-018 SHALL produce data_ok in cycle T+LATENCY for a request accepted in cycle T into an empty queue, and in cycle P+LATENCY for an entry promoted by a pop in cycle P.
REQ-019 SHALL address storage with word index data_addr[ADDR_WIDTH+1:2]; higher address bits SHALL be ignored, so addresses alias.
REQ-020 SHALL build the byte-lane mask as follows: size 0 gives lane addr[1:0]; size 1 gives lanes {1,0} when addr[1]=0 and lanes {3,2} when addr[1]=1; size 2 or 3 gives all four lanes.
REQ-021 SHALL commit a write to storage on the edge ending its data_ok cycle, updating masked lanes only.
REQ-022 SHALL drive data_rdata in a read's data_ok cycle with the full stored word, ignoring size. It SHALL be 0 during write responses and in all non-data_ok cycles.
REQ-023 SHALL return responses strictly in acceptance order; a read queued behind a write to the same word SHALL return the written data.
REQ-024 SHALL allow acceptance and response in the same cycle, with the queue count unchanged.

Reset
REQ-025 SHALL, while resetn=0, empty the queue, clear the counter, and drive data_data_ok=0, data_rdata=0 and data_addr_ok=1.
REQ-026 SHALL discard outstanding requests on reset mid-operation and emit no data_ok for them; no pending write SHALL be committed.
REQ-027 SHALL NOT reset storage contents.

Configuration
REQ-028 SHALL, with macro RESP_RANDOM_STALL_EN defined, run a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1) that advances every cycle, and gate data_addr_ok with lfsr[0]==0 in addition to REQ-015.
REQ-029 SHALL, without RESP_RANDOM_STALL_EN, contain no LFSR, with data_addr_ok exactly per REQ-015. Ordering, latency-from-head and data rules SHALL be identical in both builds.

Verification (LATENCY=2, DEPTH=2, macro undefined unless stated)
REQ-030 SHALL cover: write size 2, addr 0x40, wdata 0x12345678 accepted at T -> data_ok at T+2; then read 0x40 -> data_ok with rdata 0x12345678.
REQ-031 SHALL cover: write size 0, addr 0x41, wdata 0x0000AB00 -> a following read of 0x40 returns 0x1234AB78.
REQ-032 SHALL cover: write size 1, addr 0x42, wdata 0xBEEF0000 -> a following read of 0x40 returns 0xBEEFAB78.
REQ-033 SHALL cover: data_req held for 3 requests from cycle T -> accepts at T and T+1; addr_ok=0 at T+2; third accepted at T+3; data_ok at T+2, T+4 and T+6, in order.
REQ-034 SHALL cover: resetn pulsed low with 2 requests outstanding -> no data_ok afterward; addr_ok=1 during reset and after release; stored word unchanged by the discarded write.
REQ-035 SHALL cover, with RESP_RANDOM_STALL_EN defined: 20 random requests -> addr_ok low whenever lfsr[0]=1, all 20 data_ok delivered in order with correct data.

Source files
------------

// File: rtl/data_sram_responder.sv
// data_sram_responder: in-order SRAM responder for a req/addr_ok/data_ok bus.
// Accepted requests wait in a DEPTH-entry queue. The head is answered
// LATENCY cycles after it reaches the head of the queue. Writes update
// storage on the edge that ends their data_ok cycle, so a read queued behind
// a write to the same word sees the written data.
// Optional feature: define RESP_RANDOM_STALL_EN to add LFSR-driven random
// addr_ok stalls. The default build has no stall logic.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [3:0] LOAD_C  = 4'(LATENCY - 1);

  // The entry keeps only the word index and the lane mask, which are worked
  // out at acceptance, because the upper address bits never matter.
  typedef struct packed {
    logic                  wr;
    logic [3:0]            mask;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           wdata;
  } entry_t;

  entry_t          q_q [DEPTH];
  entry_t          q_d [DEPTH];
  logic [2:0]      count_q, count_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     mem [2**ADDR_WIDTH];

  entry_t          new_e;
  logic [3:0]      lane_mask;
  logic [2:0]      wr_idx;
  logic            room;
  logic            push;
  logic            pop;

  // Address bits above the word index alias and are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr[31:ADDR_WIDTH+2];

  assign room = (count_q < DEPTH_C);

`ifdef RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11, stepped every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  // Random stall while lfsr[0] is set. While in reset addr_ok is held high.
  assign data_addr_ok = room & (~lfsr_q[0] | ~resetn);
`else
  assign data_addr_ok = room;
`endif

  assign push         = data_req & data_addr_ok;
  assign pop          = (count_q != 3'd0) && (cnt_q == 4'd0);
  assign data_data_ok = pop;
  assign data_rdata   = (pop && !q_q[0].wr) ? mem[q_q[0].idx] : 32'h0;

  // Byte-lane mask from size and the low address bits. Size 3 counts as a word.
  always_comb begin
    lane_mask = 4'b1111;
    case (data_size)
      2'd0:    lane_mask = 4'b0001 << data_addr[1:0];
      2'd1:    lane_mask = data_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Queue entry built from the incoming request.
  always_comb begin
    new_e       = '0;
    new_e.wr    = data_wr;
    new_e.mask  = lane_mask;
    new_e.idx   = data_addr[ADDR_WIDTH+1:2];
    new_e.wdata = data_wdata;
  end

  // Shift queue. Slot 0 is the head. On a pop the entries shift down and a
  // push in the same cycle lands one slot lower.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) q_d[i] = q_q[i];
    wr_idx = pop ? (count_q - 3'd1) : count_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i+1];
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (3'(i) == wr_idx) q_d[i] = new_e;
      end
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  // Head countdown. It reloads when a new entry becomes head: on a pop, which
  // promotes the next entry, or on a push into an empty queue.
  always_comb begin
    cnt_d = cnt_q;
    if (pop || (push && (count_q == 3'd0))) cnt_d = LOAD_C;
    else if (cnt_q != 4'd0)                 cnt_d = cnt_q - 4'd1;
  end

  // Queue and counter state. Reset drops all outstanding requests.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 3'd0;
      cnt_q   <= 4'd0;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      count_q <= count_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
    end
  end

  // Storage commits the head write at the end of its data_ok cycle. Storage
  // contents are not reset.
  always_ff @(posedge clk) begin
    if (pop && q_q[0].wr) begin
      for (int b = 0; b < 4; b++) begin
        if (q_q[0].mask[b]) mem[q_q[0].idx][8*b +: 8] <= q_q[0].wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with LATENCY=2 and DEPTH=2.
// With RESP_RANDOM_STALL_EN defined, it runs a random-stall scoreboard
// instead of the directed sequence.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  int n_assert = 0;
  int n_fail   = 0;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    data_req   = req;
    data_wr    = wr;
    data_size  = sz;
    data_addr  = a;
    data_wdata = wd;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

`ifdef RESP_RANDOM_STALL_EN
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr = 16'hACE1;
    else         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end
`else
  // Single request issued alone. It is accepted at T and answered at T+2.
  task automatic txn(input string tag, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    drive(1'b1, wr, sz, a, wd);
    @(negedge clk);
    chk({tag, "_addr_ok"}, {31'b0, data_addr_ok}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_ok_t1"}, {31'b0, data_data_ok}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk({tag, "_ok_t2"}, {31'b0, data_data_ok}, 32'd1);
    chk({tag, "_rdata"}, data_rdata, exp_rd);
    next_cycle();
  endtask
`endif

  initial begin
    resetn = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("rst_data_ok", {31'b0, data_data_ok}, 32'd0);
    chk("rst_rdata", data_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

`ifdef RESP_RANDOM_STALL_EN
    begin
      logic [31:0] m_mem [8];
      logic [31:0] exp_q [$];
      logic        c_wr;
      logic [2:0]  c_w;
      logic [31:0] c_d;
      int          i = 0;
      int          n_ok = 0;
      int          cyc = 0;
      c_wr = 1'b1; c_w = 3'd0; c_d = $urandom;
      while ((i < 20 || exp_q.size() != 0) && cyc < 2000) begin
        if (i < 20) drive(1'b1, c_wr, 2'd2, {27'h0, c_w, 2'b00}, c_d);
        else        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        if (m_lfsr[0]) chk("stall_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        if (data_data_ok) begin
          if (exp_q.size() == 0) chk("rnd_spurious_ok", 32'd1, 32'd0);
          else chk("rnd_rdata", data_rdata, exp_q.pop_front());
          n_ok++;
        end
        if (data_req && data_addr_ok) begin
          if (c_wr) begin
            m_mem[c_w] = c_d;
            exp_q.push_back(32'h0);
          end else begin
            exp_q.push_back(m_mem[c_w]);
          end
          i++;
          if (i < 8) begin
            c_wr = 1'b1; c_w = 3'(i);
          end else begin
            c_wr = 1'($urandom_range(0, 1)); c_w = 3'($urandom_range(0, 7));
          end
          c_d = $urandom;
        end
        next_cycle();
        cyc++;
      end
      chk("rnd_accepted", i, 32'd20);
      chk("rnd_delivered", n_ok, 32'd20);
    end
`else
    @(negedge clk);
    chk("post_rst_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    next_cycle();

    // word write, read back
    txn("wr_word", 1'b1, 2'd2, 32'h40, 32'h12345678, 32'h0);
    txn("rd_word", 1'b0, 2'd2, 32'h40, 32'h0, 32'h12345678);
    // byte write lane 1
    txn("wr_byte", 1'b1, 2'd0, 32'h41, 32'h0000AB00, 32'h0);
    txn("rd_byte", 1'b0, 2'd2, 32'h40, 32'h0, 32'h1234AB78);
    // halfword write upper lanes
    txn("wr_half", 1'b1, 2'd1, 32'h42, 32'hBEEF0000, 32'h0);
    txn("rd_half", 1'b0, 2'd2, 32'h40, 32'h0, 32'hBEEFAB78);
    // address bit 12 lies above the 10-bit word index, so it aliases
    txn("rd_alias", 1'b0, 2'd2, 32'h1040, 32'h0, 32'hBEEFAB78);
    // size 3 acts as a word; a byte-size read still returns the full word
    txn("wr_size3", 1'b1, 2'd3, 32'h80, 32'hCAFEF00D, 32'h0);
    txn("wr_lane3", 1'b1, 2'd0, 32'h83, 32'h11000000, 32'h0);
    txn("rd_size0", 1'b0, 2'd0, 32'h80, 32'h0, 32'h11FEF00D);

    // three back-to-back requests with data_req held
    drive(1'b1, 1'b1, 2'd2, 32'h100, 32'hA5A5A5A5);                // T
    @(negedge clk);
    chk("b2b_t0_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("b2b_t0_ok", {31'b0, data_data_ok}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);                       // T+1
    @(negedge clk);
    chk("b2b_t1_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("b2b_t1_ok", {31'b0, data_data_ok}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b1, 2'd2, 32'h104, 32'h0BADBEEF);                // T+2
    @(negedge clk);
    chk("b2b_t2_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    chk("b2b_t2_ok", {31'b0, data_data_ok}, 32'd1);
    chk("b2b_t2_rdata", data_rdata, 32'h0);
    next_cycle();                                                  // T+3
    @(negedge clk);
    chk("b2b_t3_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("b2b_t3_ok", {31'b0, data_data_ok}, 32'd0);
    chk("b2b_t3_rdata_idle", data_rdata, 32'h0);
    next_cycle();                                                  // T+4
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_t4_ok", {31'b0, data_data_ok}, 32'd1);
    chk("b2b_t4_rdata", data_rdata, 32'hA5A5A5A5);
    next_cycle();                                                  // T+5
    @(negedge clk);
    chk("b2b_t5_ok", {31'b0, data_data_ok}, 32'd0);
    next_cycle();                                                  // T+6
    @(negedge clk);
    chk("b2b_t6_ok", {31'b0, data_data_ok}, 32'd1);
    chk("b2b_t6_rdata", data_rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("b2b_t7_ok", {31'b0, data_data_ok}, 32'd0);
    next_cycle();
    txn("rd_b2b_c", 1'b0, 2'd2, 32'h104, 32'h0, 32'h0BADBEEF);

    // accept and respond in the same cycle
    drive(1'b1, 1'b1, 2'd2, 32'h200, 32'h55556666);                // T
    next_cycle();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);                         // T+1
    next_cycle();
    drive(1'b1, 1'b0, 2'd2, 32'h200, 32'h0);                       // T+2
    @(negedge clk);
    chk("same_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("same_ok", {31'b0, data_data_ok}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);                         // T+3
    @(negedge clk);
    chk("same_t3_ok", {31'b0, data_data_ok}, 32'd0);
    chk("same_t3_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    next_cycle();                                                  // T+4
    @(negedge clk);
    chk("same_t4_ok", {31'b0, data_data_ok}, 32'd1);
    chk("same_t4_rdata", data_rdata, 32'h55556666);
    next_cycle();

    // reset with two requests outstanding; the pending write must be dropped
    drive(1'b1, 1'b1, 2'd2, 32'h40, 32'hDEADDEAD);
    next_cycle();
    drive(1'b1, 1'b1, 2'd2, 32'h44, 32'hFEEDFACE);
    @(negedge clk);
    chk("mid_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_ok", {31'b0, data_data_ok}, 32'd0);
    chk("mid_rst_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("mid_rst_rdata", data_rdata, 32'h0);
    next_cycle();
    next_cycle();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_rst_ok", {31'b0, data_data_ok}, 32'd0);
      chk("after_rst_addr_ok", {31'b0, data_addr_ok}, 32'd1);
      next_cycle();
    end
    txn("rd_after_rst", 1'b0, 2'd2, 32'h40, 32'h0, 32'hBEEFAB78);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
